// File: rtl/rob_commit_if.sv
// ROB-reader / retirement bus between the ROB+rename side (master) and rob_commit (slave).
// COMMIT_TRACE_EN adds the per-lane difftest trace outputs.
interface rob_commit_if #(
    parameter int COMMIT_WIDTH = 2,
    parameter int ROB_DEPTH    = 32,
    parameter int PREG_W       = 6,
    parameter int PTR_W        = $clog2(ROB_DEPTH) + 1
);
    logic [PTR_W-1:0]               rob_tail_i;
    logic [PTR_W-1:0]               rob_head_o;
    logic [COMMIT_WIDTH-1:0]        rob_complete_i;
    logic [COMMIT_WIDTH-1:0]        rob_wen_i;
    logic [COMMIT_WIDTH*5-1:0]      rob_creg_i;
    logic [COMMIT_WIDTH*PREG_W-1:0] rob_preg_i;
    logic [COMMIT_WIDTH-1:0]        rob_mispred_i;
    logic [COMMIT_WIDTH*64-1:0]     rob_target_i;
    logic [COMMIT_WIDTH*64-1:0]     rob_pc_i;
    logic [COMMIT_WIDTH-1:0]        retire_valid_o;
    logic [COMMIT_WIDTH-1:0]        free_valid_o;
    logic [COMMIT_WIDTH*PREG_W-1:0] free_preg_o;
    logic [COMMIT_WIDTH-1:0]        restore_valid_o;
    logic [COMMIT_WIDTH*5-1:0]      restore_creg_o;
    logic [COMMIT_WIDTH*PREG_W-1:0] restore_preg_o;
    logic                           flush_o;
    logic [63:0]                    redirect_pc_o;
    logic                           stall_o;
`ifdef COMMIT_TRACE_EN
    logic [COMMIT_WIDTH-1:0]            trace_valid_o;
    logic [COMMIT_WIDTH*64-1:0]         trace_pc_o;
    logic [COMMIT_WIDTH*(5+PREG_W)-1:0] trace_wdst_o;

    modport master (
        output rob_tail_i, rob_complete_i, rob_wen_i, rob_creg_i, rob_preg_i,
               rob_mispred_i, rob_target_i, rob_pc_i,
        input  rob_head_o, retire_valid_o, free_valid_o, free_preg_o, restore_valid_o,
               restore_creg_o, restore_preg_o, flush_o, redirect_pc_o, stall_o,
               trace_valid_o, trace_pc_o, trace_wdst_o
    );
    modport slave (
        input  rob_tail_i, rob_complete_i, rob_wen_i, rob_creg_i, rob_preg_i,
               rob_mispred_i, rob_target_i, rob_pc_i,
        output rob_head_o, retire_valid_o, free_valid_o, free_preg_o, restore_valid_o,
               restore_creg_o, restore_preg_o, flush_o, redirect_pc_o, stall_o,
               trace_valid_o, trace_pc_o, trace_wdst_o
    );
`else
    modport master (
        output rob_tail_i, rob_complete_i, rob_wen_i, rob_creg_i, rob_preg_i,
               rob_mispred_i, rob_target_i, rob_pc_i,
        input  rob_head_o, retire_valid_o, free_valid_o, free_preg_o, restore_valid_o,
               restore_creg_o, restore_preg_o, flush_o, redirect_pc_o, stall_o
    );
    modport slave (
        input  rob_tail_i, rob_complete_i, rob_wen_i, rob_creg_i, rob_preg_i,
               rob_mispred_i, rob_target_i, rob_pc_i,
        output rob_head_o, retire_valid_o, free_valid_o, free_preg_o, restore_valid_o,
               restore_creg_o, restore_preg_o, flush_o, redirect_pc_o, stall_o
    );
`endif
endinterface

// File: rtl/rob_commit.sv
// In-order ROB retirement: keeps the architectural RAT, frees superseded pregs, flushes on
// a retiring mispredict and replays the RAT into rename. Optional macro: COMMIT_TRACE_EN.
module rob_commit #(
    parameter int COMMIT_WIDTH = 2,
    parameter int ROB_DEPTH    = 32,
    parameter int PREG_W       = 6,
    parameter int CREG_NUM     = 32,
    parameter int PTR_W        = $clog2(ROB_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         resetn,
    rob_commit_if.slave  bus
);
    localparam int IDX_W = $clog2(CREG_NUM);
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CREG_NUM - COMMIT_WIDTH);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_RESTORE = 2'd2} state_t;

    state_t                         state_r, state_next_s;
    logic [PTR_W-1:0]               head_r, head_next_s, occ_s;
    logic [IDX_W-1:0]               idx_r, idx_next_s;
    logic [PREG_W-1:0]              arch_rat_r [CREG_NUM];
    logic [PREG_W-1:0]              rat_next_s [CREG_NUM];
    logic [COMMIT_WIDTH-1:0]        elig_s, free_valid_s, restore_valid_s;
    logic [CNT_W-1:0]               retire_cnt_s;
    logic [COMMIT_WIDTH*PREG_W-1:0] free_preg_s, restore_preg_s;
    logic [COMMIT_WIDTH*5-1:0]      restore_creg_s;
    logic                           mispred_hit_s;
    logic [63:0]                    target_s;

    logic [COMMIT_WIDTH-1:0]        retire_valid_r, free_valid_r, restore_valid_r;
    logic [COMMIT_WIDTH*PREG_W-1:0] free_preg_r, restore_preg_r;
    logic [COMMIT_WIDTH*5-1:0]      restore_creg_r;
    logic                           flush_r, stall_r;
    logic [63:0]                    redirect_pc_r;

    // Lane eligibility and in-order RAT update; a younger lane sees the older lane's write.
    always_comb begin : retire_comb
        logic       blocked;
        logic       lane_ok;
        logic [4:0] creg;
        occ_s         = bus.rob_tail_i - head_r;
        blocked       = (state_r != ST_RUN);
        elig_s        = '0;
        retire_cnt_s  = '0;
        free_valid_s  = '0;
        free_preg_s   = '0;
        rat_next_s    = arch_rat_r;
        mispred_hit_s = 1'b0;
        target_s      = redirect_pc_r;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            creg         = bus.rob_creg_i[i*5 +: 5];
            lane_ok      = !blocked && (PTR_W'(i) < occ_s) && bus.rob_complete_i[i];
            elig_s[i]    = lane_ok;
            retire_cnt_s = retire_cnt_s + CNT_W'(lane_ok);
            if (lane_ok && bus.rob_wen_i[i] && (creg != 5'd0)) begin
                free_valid_s[i]                   = 1'b1;
                free_preg_s[i*PREG_W +: PREG_W]   = rat_next_s[creg];
                rat_next_s[creg]                  = bus.rob_preg_i[i*PREG_W +: PREG_W];
            end else begin
                free_valid_s[i] = 1'b0;
            end
            if (lane_ok && bus.rob_mispred_i[i]) begin
                mispred_hit_s = 1'b1;
                target_s      = bus.rob_target_i[i*64 +: 64];
            end else begin
                mispred_hit_s = mispred_hit_s;
            end
            blocked = blocked || !lane_ok || bus.rob_mispred_i[i];
        end
    end

    // Next-state, head and restore-index selection.
    always_comb begin
        state_next_s = state_r;
        head_next_s  = head_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_RUN: begin
                head_next_s  = head_r + PTR_W'(retire_cnt_s);
                state_next_s = mispred_hit_s ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                head_next_s  = '0;
                idx_next_s   = '0;
                state_next_s = ST_RESTORE;
            end
            ST_RESTORE: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    idx_next_s = idx_r + IDX_W'(COMMIT_WIDTH);
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Restore group presented during the upcoming RESTORE cycle.
    always_comb begin
        logic [IDX_W-1:0] ridx;
        restore_valid_s = (state_next_s == ST_RESTORE) ? '1 : '0;
        restore_creg_s  = '0;
        restore_preg_s  = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            ridx                               = idx_next_s + IDX_W'(i);
            restore_creg_s[i*5 +: 5]           = 5'(ridx);
            restore_preg_s[i*PREG_W +: PREG_W] = arch_rat_r[ridx];
        end
    end

    // State, architectural RAT and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= ST_RUN;
            head_r          <= '0;
            idx_r           <= '0;
            retire_valid_r  <= '0;
            free_valid_r    <= '0;
            free_preg_r     <= '0;
            restore_valid_r <= '0;
            restore_creg_r  <= '0;
            restore_preg_r  <= '0;
            flush_r         <= 1'b0;
            stall_r         <= 1'b0;
            redirect_pc_r   <= 64'd0;
            for (int r = 0; r < CREG_NUM; r++) begin
                arch_rat_r[r] <= PREG_W'(r);
            end
        end else begin
            state_r         <= state_next_s;
            head_r          <= head_next_s;
            idx_r           <= idx_next_s;
            retire_valid_r  <= elig_s;
            free_valid_r    <= free_valid_s;
            free_preg_r     <= free_preg_s;
            restore_valid_r <= restore_valid_s;
            restore_creg_r  <= restore_creg_s;
            restore_preg_r  <= restore_preg_s;
            flush_r         <= (state_next_s == ST_FLUSH);
            stall_r         <= (state_next_s != ST_RUN);
            redirect_pc_r   <= target_s;
            arch_rat_r      <= rat_next_s;
        end
    end

    assign bus.rob_head_o      = head_r;
    assign bus.retire_valid_o  = retire_valid_r;
    assign bus.free_valid_o    = free_valid_r;
    assign bus.free_preg_o     = free_preg_r;
    assign bus.restore_valid_o = restore_valid_r;
    assign bus.restore_creg_o  = restore_creg_r;
    assign bus.restore_preg_o  = restore_preg_r;
    assign bus.flush_o         = flush_r;
    assign bus.redirect_pc_o   = redirect_pc_r;
    assign bus.stall_o         = stall_r;

`ifdef COMMIT_TRACE_EN
    logic [COMMIT_WIDTH-1:0]            trace_valid_r;
    logic [COMMIT_WIDTH*64-1:0]         trace_pc_r;
    logic [COMMIT_WIDTH*(5+PREG_W)-1:0] trace_wdst_r;

    // Difftest trace captured on the same edge as retire_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trace_valid_r <= '0;
            trace_pc_r    <= '0;
            trace_wdst_r  <= '0;
        end else begin
            trace_valid_r <= elig_s;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                trace_pc_r[i*64 +: 64] <= elig_s[i] ? bus.rob_pc_i[i*64 +: 64] : 64'd0;
                trace_wdst_r[i*(5+PREG_W) +: (5+PREG_W)] <= elig_s[i] ?
                    {bus.rob_creg_i[i*5 +: 5], bus.rob_preg_i[i*PREG_W +: PREG_W]} : '0;
            end
        end
    end

    assign bus.trace_valid_o = trace_valid_r;
    assign bus.trace_pc_o    = trace_pc_r;
    assign bus.trace_wdst_o  = trace_wdst_r;
`endif
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: table of single-cycle retire vectors plus hand-written
// mispredict/restore, pointer-wrap and reset-abort sequences.
module tb_rob_commit;
    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    rob_commit_if #(.COMMIT_WIDTH(2), .ROB_DEPTH(32), .PREG_W(6)) bus_if ();

    rob_commit #(.COMMIT_WIDTH(2), .ROB_DEPTH(32), .PREG_W(6), .CREG_NUM(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] tail;
        logic [1:0] comp;
        logic [1:0] wen;
        logic [1:0] mis;
        logic [4:0] c0;
        logic [4:0] c1;
        logic [5:0] p0;
        logic [5:0] p1;
        logic [1:0] e_ret;
        logic [1:0] e_fv;
        logic [5:0] e_f0;
        logic [5:0] e_f1;
        logic [5:0] e_head;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAT contents after the table vectors: 3->42, 4->41, 7->51, others identity.
    function automatic logic [5:0] exp_rat(input int r);
        if (r == 3) return 6'd42;
        else if (r == 4) return 6'd41;
        else if (r == 7) return 6'd51;
        else return 6'(r);
    endfunction

    task automatic drive(input logic [5:0] tail, input logic [1:0] comp, input logic [1:0] wen,
                         input logic [1:0] mis, input logic [4:0] c0, input logic [4:0] c1,
                         input logic [5:0] p0, input logic [5:0] p1);
        bus_if.rob_tail_i     = tail;
        bus_if.rob_complete_i = comp;
        bus_if.rob_wen_i      = wen;
        bus_if.rob_mispred_i  = mis;
        bus_if.rob_creg_i     = {c1, c0};
        bus_if.rob_preg_i     = {p1, p0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{tail:6'd2, comp:2'b11, wen:2'b11, mis:2'b00, c0:5'd3, c1:5'd4, p0:6'd40, p1:6'd41,
                    e_ret:2'b11, e_fv:2'b11, e_f0:6'd3, e_f1:6'd4, e_head:6'd2};
        vecs[1] = '{tail:6'd4, comp:2'b10, wen:2'b11, mis:2'b00, c0:5'd7, c1:5'd7, p0:6'd50, p1:6'd51,
                    e_ret:2'b00, e_fv:2'b00, e_f0:6'd0, e_f1:6'd0, e_head:6'd2};
        vecs[2] = '{tail:6'd4, comp:2'b11, wen:2'b11, mis:2'b00, c0:5'd7, c1:5'd7, p0:6'd50, p1:6'd51,
                    e_ret:2'b11, e_fv:2'b11, e_f0:6'd7, e_f1:6'd50, e_head:6'd4};
        vecs[3] = '{tail:6'd4, comp:2'b11, wen:2'b11, mis:2'b00, c0:5'd9, c1:5'd9, p0:6'd60, p1:6'd61,
                    e_ret:2'b00, e_fv:2'b00, e_f0:6'd0, e_f1:6'd0, e_head:6'd4};
        vecs[4] = '{tail:6'd5, comp:2'b11, wen:2'b11, mis:2'b00, c0:5'd3, c1:5'd9, p0:6'd42, p1:6'd43,
                    e_ret:2'b01, e_fv:2'b01, e_f0:6'd40, e_f1:6'd0, e_head:6'd5};
        vecs[5] = '{tail:6'd7, comp:2'b11, wen:2'b01, mis:2'b00, c0:5'd0, c1:5'd5, p0:6'd44, p1:6'd45,
                    e_ret:2'b11, e_fv:2'b00, e_f0:6'd0, e_f1:6'd0, e_head:6'd7};

        resetn = 1'b0;
        drive(6'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
        bus_if.rob_target_i = {64'h0000_0000_0000_dead, 64'h0000_0000_8000_1000};
        bus_if.rob_pc_i     = {64'h0000_0000_0000_1004, 64'h0000_0000_0000_1000};
        repeat (3) @(posedge clk);
        #1;
        check("rst_head",   64'(bus_if.rob_head_o), 64'd0);
        check("rst_retire", 64'(bus_if.retire_valid_o), 64'd0);
        check("rst_rat5",   64'(dut.arch_rat_r[5]), 64'd5);
        check("rst_flush",  64'(bus_if.flush_o), 64'd0);
        check("rst_stall",  64'(bus_if.stall_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("idle_head", 64'(bus_if.rob_head_o), 64'd0);

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].tail, vecs[i].comp, vecs[i].wen, vecs[i].mis,
                  vecs[i].c0, vecs[i].c1, vecs[i].p0, vecs[i].p1);
            step();
            check($sformatf("v%0d_retire", i), 64'(bus_if.retire_valid_o), 64'(vecs[i].e_ret));
            check($sformatf("v%0d_free_v", i), 64'(bus_if.free_valid_o), 64'(vecs[i].e_fv));
            check($sformatf("v%0d_head", i),   64'(bus_if.rob_head_o), 64'(vecs[i].e_head));
            if (vecs[i].e_fv[0])
                check($sformatf("v%0d_free0", i), 64'(bus_if.free_preg_o[5:0]), 64'(vecs[i].e_f0));
            if (vecs[i].e_fv[1])
                check($sformatf("v%0d_free1", i), 64'(bus_if.free_preg_o[11:6]), 64'(vecs[i].e_f1));
        end
        check("rat7_final", 64'(dut.arch_rat_r[7]), 64'd51);

        // Mispredict on lane 0: lane 1 must not retire.
        drive(6'd9, 2'b11, 2'b00, 2'b01, 5'd0, 5'd0, 6'd0, 6'd0);
        step();
        check("mp_retire",   64'(bus_if.retire_valid_o), 64'h1);
        check("mp_head",     64'(bus_if.rob_head_o), 64'd8);
        check("mp_flush",    64'(bus_if.flush_o), 64'd1);
        check("mp_stall",    64'(bus_if.stall_o), 64'd1);
        check("mp_redirect", bus_if.redirect_pc_o, 64'h8000_1000);
        drive(6'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
        step();
        check("rs_flush_drop", 64'(bus_if.flush_o), 64'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("rs%0d_valid", k), 64'(bus_if.restore_valid_o), 64'h3);
            check($sformatf("rs%0d_creg", k),  64'(bus_if.restore_creg_o),
                  64'({5'(2*k+1), 5'(2*k)}));
            check($sformatf("rs%0d_preg", k),  64'(bus_if.restore_preg_o),
                  64'({exp_rat(2*k+1), exp_rat(2*k)}));
            check($sformatf("rs%0d_stall", k), 64'(bus_if.stall_o), 64'd1);
            check($sformatf("rs%0d_retire", k), 64'(bus_if.retire_valid_o), 64'd0);
            step();
        end
        check("post_rs_stall", 64'(bus_if.stall_o), 64'd0);
        check("post_rs_valid", 64'(bus_if.restore_valid_o), 64'd0);
        check("post_rs_head",  64'(bus_if.rob_head_o), 64'd0);

        // Walk head to slot 31, then retire across the wrap.
        drive(6'd31, 2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
        for (int n = 0; n < 40 && bus_if.rob_head_o != 6'd31; n++) step();
        check("walk_head31", 64'(bus_if.rob_head_o), 64'd31);
        drive(6'd33, 2'b11, 2'b11, 2'b00, 5'd1, 5'd2, 6'd60, 6'd61);
        step();
        check("wrap_retire", 64'(bus_if.retire_valid_o), 64'h3);
        check("wrap_head",   64'(bus_if.rob_head_o), 64'd33);
        check("wrap_free",   64'(bus_if.free_preg_o), 64'({6'd2, 6'd1}));

        // Reset asserted mid-RESTORE returns to reset values at once.
        drive(6'd34, 2'b01, 2'b00, 2'b01, 5'd0, 5'd0, 6'd0, 6'd0);
        step();
        check("mp2_flush", 64'(bus_if.flush_o), 64'd1);
        drive(6'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
        step();
        step();
        check("mp2_restoring", 64'(bus_if.restore_valid_o), 64'h3);
        resetn = 1'b0;
        #1;
        check("abort_stall", 64'(bus_if.stall_o), 64'd0);
        check("abort_valid", 64'(bus_if.restore_valid_o), 64'd0);
        check("abort_head",  64'(bus_if.rob_head_o), 64'd0);
        check("abort_rat7",  64'(dut.arch_rat_r[7]), 64'd7);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("abort_run", 64'(bus_if.stall_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order retirement engine at the reader end of the ROB. Rename writes ROB entries and speculative RAT updates; this block reads them back.
- Each cycle it examines up to COMMIT_WIDTH entries at the head and retires the completed ones. It maintains the architectural (committed) RAT and returns superseded physical registers to the free list.
- On a retiring mispredicted branch it flushes the pipeline. It then replays the architectural RAT into the speculative RAT through rat_wreq-style restore writes.

Parameters:
- COMMIT_WIDTH, 2, retire lanes per cycle.
- ROB_DEPTH, 32, ROB entries (power of 2).
- PREG_W, 6, physical register id width.
- CREG_NUM, 32, architectural registers (multiple of COMMIT_WIDTH).
- PTR_W, $clog2(ROB_DEPTH)+1, ROB pointer width including the wrap bit.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- rob_tail_i  in  PTR_W  ROB tail pointer from rename
- rob_head_o  out  PTR_W  head pointer; lane i reads slot (rob_head_o+i) mod ROB_DEPTH
- rob_complete_i  in  COMMIT_WIDTH  per-lane entry complete
- rob_wen_i  in  COMMIT_WIDTH  per-lane entry writes a destination
- rob_creg_i  in  COMMIT_WIDTH*5  per-lane architectural destination
- rob_preg_i  in  COMMIT_WIDTH*PREG_W  per-lane physical destination
- rob_mispred_i  in  COMMIT_WIDTH  per-lane branch mispredicted
- rob_target_i  in  COMMIT_WIDTH*64  per-lane correct branch target
- rob_pc_i  in  COMMIT_WIDTH*64  per-lane pc
- retire_valid_o  out  COMMIT_WIDTH  lanes retired last cycle
- free_valid_o  out  COMMIT_WIDTH  free-list push valid
- free_preg_o  out  COMMIT_WIDTH*PREG_W  physical registers freed
- restore_valid_o  out  COMMIT_WIDTH  speculative-RAT restore write valid
- restore_creg_o  out  COMMIT_WIDTH*5  restore index
- restore_preg_o  out  COMMIT_WIDTH*PREG_W  restore value
- flush_o  out  1  pipeline flush pulse
- redirect_pc_o  out  64  fetch redirect target
- stall_o  out  1  rename must not allocate

Behaviour:
- Reset (resetn low, asynchronous):
  - head=0, state=RUN.
  - All valid outputs, flush_o and stall_o are 0; redirect_pc_o=0.
  - Architectural RAT entry r holds preg r.
- Occupancy is rob_tail_i-rob_head_o, computed modulo 2^PTR_W. Head==tail with equal wrap bits means empty. Equal index with different wrap bits means full (count=ROB_DEPTH).
- RUN state, lane i is eligible when all of the following hold:
  - i < occupancy;
  - rob_complete_i[i]=1;
  - every lane j<i is eligible;
  - no lane j<i has rob_mispred_i=1.
  - A mispredicted lane is itself retired; the lanes after it are not.
- Retirement is registered with 1-cycle latency. At the clock edge:
  - head advances by the number of eligible lanes, wrapping naturally through the wrap bit.
  - retire_valid_o is updated.
- Per retired lane with rob_wen_i=1 and creg!=0:
  - free_preg_o = the architectural RAT's old value for that creg, and free_valid_o=1.
  - The architectural RAT entry is set to rob_preg_i.
  - Same-creg hazard within one cycle: the older lane's new preg is what the younger lane frees, and the final RAT value comes from the younger lane.
  - creg 0 is never written and never frees.
- Mispredict retired → next state FLUSH; redirect_pc_o latches rob_target_i of that lane.
- FLUSH (exactly 1 cycle):
  - flush_o=1, stall_o=1.
  - head is set to 0; rename resets the tail to 0 on flush.
  - restore index is set to 0; next state RESTORE.
- RESTORE:
  - stall_o=1.
  - Each cycle, lanes i=0..COMMIT_WIDTH-1 drive restore_creg=idx+i, restore_preg=arch_rat[idx+i], restore_valid=1.
  - idx increases by COMMIT_WIDTH each cycle.
  - After the group containing CREG_NUM-1, next state RUN.
  - With defaults this takes 16 cycles; no retirement occurs in this state.
- Reset asserted in FLUSH or RESTORE aborts immediately to reset values.
- Empty ROB: no retirement; head holds.

Optional Feature:
- COMMIT_TRACE_EN: adds outputs trace_valid_o[COMMIT_WIDTH], trace_pc_o and trace_wdst_o.
- These are registered alongside retire_valid_o and carry the pc, creg and preg of each retired lane, for difftest.
- Without the macro the ports and the logic are absent.

Test Plan:
- Reset, tail=0 → head=0, no retire, arch RAT[5]=5, flush_o=0, stall_o=0.
- Tail=2, both lanes complete, creg 3/4 with preg 40/41, arch RAT initial → next cycle retire_valid=11, free_preg 3 and 4, head=2.
- Lane0 incomplete, lane1 complete → retire_valid=00 and head holds. Lane0 later completes → both retire together.
- Both lanes write creg 7 with preg 50/51, RAT[7]=7 → frees 7 and 50; RAT[7]=51.
- Lane0 mispredicted with target 0x80001000 → retires alone. Next cycle flush_o=1 and redirect=0x80001000. Then 16 RESTORE cycles with creg 0..31 and stall_o=1, then RUN with head=0.
- Head=31 (wrap bit 0), tail=33, both lanes complete → slots 31 and 0 retire; head=33 with wrap bit set.
